// File: rtl/ireg_sched.sv
// Skewing tile scheduler feeding the row input registers of the systolic array.
// Define IREG_SCHED_AUTOCLR_EN to add the post-drain CLEAR state and ireg_clr pulse.
module ireg_sched #(
    parameter int WIDTH = 16,
    parameter int ROWS  = 4,
    parameter int MAX_K = 255,
    parameter int KW    = $clog2(MAX_K + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [KW-1:0]           i_k_len,
    output logic                    o_busy,
    output logic                    o_done,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [ROWS*WIDTH-1:0]   i_in_data,
    output logic [ROWS-1:0]         o_ireg_en,
    output logic                    o_ireg_clr,
    output logic [ROWS*WIDTH-1:0]   o_row_data
);

    localparam int DW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_CLEAR
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [KW-1:0]   r_klen;
    logic [KW-1:0]   r_cnt;
    logic [DW-1:0]   r_dcnt;
    logic            w_beat;
    logic            w_step;
    logic            w_klast;
    logic            w_dlast;
    logic            w_accept;

    assign w_beat   = (r_state == S_LOAD) && i_in_valid;
    assign w_step   = w_beat || (r_state == S_DRAIN);
    assign w_klast  = (r_cnt == r_klen - 1'b1);
    assign w_dlast  = (r_dcnt == DW'(ROWS - 1));
    assign w_accept = (r_state == S_IDLE) && i_start;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (i_k_len != '0) ? S_LOAD : S_DRAIN;
                end
            end
            S_LOAD: begin
                if (w_beat && w_klast) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_dlast) begin
`ifdef IREG_SCHED_AUTOCLR_EN
                    w_next = S_CLEAR;
`else
                    w_next = S_IDLE;
`endif
                end
            end
            S_CLEAR: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Beat counter only ever reaches k_len, so MAX_K never wraps it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_klen <= '0;
            r_cnt  <= '0;
            r_dcnt <= '0;
        end else begin
            if (w_accept) begin
                r_klen <= i_k_len;
                r_cnt  <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_DRAIN) begin
                r_dcnt <= w_dlast ? '0 : r_dcnt + 1'b1;
            end else begin
                r_dcnt <= '0;
            end
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_in_ready = (r_state == S_LOAD);

`ifdef IREG_SCHED_AUTOCLR_EN
    assign o_done     = (r_state == S_CLEAR);
    assign o_ireg_clr = (r_state == S_CLEAR);
`else
    assign o_done     = (r_state == S_DRAIN) && w_dlast;
    assign o_ireg_clr = 1'b0;
`endif

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic             w_act;
        logic [WIDTH-1:0] w_dat;
        logic             r_en;
        logic [WIDTH-1:0] r_out;

        if (r == 0) begin : g_direct
            assign w_act = w_beat;
            assign w_dat = i_in_data[0 +: WIDTH];
        end else begin : g_dly
            // Row r holds r stages; they only advance on a step.
            logic [r-1:0]     r_a;
            logic [WIDTH-1:0] r_d [r];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_a <= '0;
                    for (int k = 0; k < r; k++) begin
                        r_d[k] <= '0;
                    end
                end else if (w_step) begin
                    r_a[0] <= w_beat;
                    r_d[0] <= i_in_data[r*WIDTH +: WIDTH];
                    for (int k = 1; k < r; k++) begin
                        r_a[k] <= r_a[k-1];
                        r_d[k] <= r_d[k-1];
                    end
                end
            end

            assign w_act = r_a[r-1];
            assign w_dat = r_d[r-1];
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_en  <= 1'b0;
                r_out <= '0;
            end else begin
                r_en  <= w_step && w_act;
                r_out <= (w_step && w_act) ? w_dat : '0;
            end
        end

        assign o_ireg_en[r]                 = r_en;
        assign o_row_data[r*WIDTH +: WIDTH] = r_out;
    end

endmodule
